// File: rtl/free_list_ctrl.sv
// free_list_ctrl: circular free list of physical registers with flush rollback to a retire pointer (define FREE_LIST_BYPASS_EN to bypass enqueue->dequeue when empty)
module free_list_ctrl #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ARCH_REGS     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dequeue,
  output logic [PHYS_REG_BITS-1:0] phys_reg,
  output logic                     is_free_list_empty,
  input  logic                     enqueue,
  input  logic [PHYS_REG_BITS-1:0] enqueue_reg,
  input  logic                     retire_alloc,
  input  logic                     flush,
  output logic [PHYS_REG_BITS:0]   free_count
);
  localparam int DEPTH = 2**PHYS_REG_BITS - ARCH_REGS;
  localparam int AW    = $clog2(DEPTH);
  logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
  logic [AW:0] head_q, head_d, tail_q, tail_d, ret_q, ret_d, cnt;
  logic empty, full, byp, do_deq, do_enq;
  assign empty = head_q == tail_q;
  assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
`ifdef FREE_LIST_BYPASS_EN
  assign byp = empty && enqueue && dequeue && (enqueue_reg != '0);
`else
  assign byp = 1'b0;
`endif
  // a pop frees a slot in the same cycle, so a full list still accepts a simultaneous return
  assign do_deq = dequeue && (!empty || byp);
  assign do_enq = enqueue && (enqueue_reg != '0) && (!full || do_deq);
  assign cnt    = tail_q - head_q;
  assign phys_reg           = byp ? enqueue_reg : mem_q[head_q[AW-1:0]];
  assign is_free_list_empty = empty && !byp;
  assign free_count         = (PHYS_REG_BITS+1)'(cnt);
  always_comb begin
    ret_d  = ret_q + (AW+1)'(retire_alloc);
    tail_d = tail_q + (AW+1)'(do_enq);
    head_d = flush ? ret_d : head_q + (AW+1)'(do_deq);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PHYS_REG_BITS'(ARCH_REGS + i);
      head_q <= '0;
      ret_q  <= '0;
      tail_q <= (AW+1)'(DEPTH);
    end else begin
      if (do_enq) mem_q[tail_q[AW-1:0]] <= enqueue_reg;
      head_q <= head_d;
      tail_q <= tail_d;
      ret_q  <= ret_d;
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(enqueue && (enqueue_reg != '0) && full && !do_deq))
        else $error("free_list_ctrl: enqueue while full dropped");
      assert ((AW+1)'(head_q - ret_q) <= (AW+1)'(DEPTH))
        else $error("free_list_ctrl: retire_head passed head");
    end
  end
`endif
endmodule

// File: tb/tb_free_list_ctrl.sv
// tb_free_list_ctrl: randomized and directed checks of free_list_ctrl against a counter/array reference model
module tb_free_list_ctrl;
  localparam int PB = 6, AR = 32, D = 2**PB - AR;
  logic clk = 0, rst = 0, dequeue = 0, enqueue = 0, retire_alloc = 0, flush = 0;
  logic [PB-1:0] enqueue_reg = '0, phys_reg;
  logic is_free_list_empty;
  logic [PB:0] free_count;
  int n_tot = 0, n_bad = 0;
  int m_mem [D];
  int h, t, r;
  free_list_ctrl #(.PHYS_REG_BITS(PB), .ARCH_REGS(AR)) dut (
    .clk(clk), .rst(rst), .dequeue(dequeue), .phys_reg(phys_reg),
    .is_free_list_empty(is_free_list_empty), .enqueue(enqueue), .enqueue_reg(enqueue_reg),
    .retire_alloc(retire_alloc), .flush(flush), .free_count(free_count));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < D; i++) m_mem[i] = AR + i;
    h = 0; r = 0; t = D;
    chk("rst_phys", int'(phys_reg), AR);
    chk("rst_empty", int'(is_free_list_empty), 0);
    chk("rst_count", int'(free_count), D);
  endtask
  task automatic step(input bit deq, input bit enq, input int rg, input bit ret, input bit fl);
    bit emp, full, byp, dd, de;
    dequeue = deq; enqueue = enq; enqueue_reg = PB'(rg); retire_alloc = ret; flush = fl;
    #4;
    emp = (h == t);
    full = (t - h == D);
`ifdef FREE_LIST_BYPASS_EN
    byp = emp && enq && deq && rg != 0;
`else
    byp = 0;
`endif
    chk("phys_reg", int'(phys_reg), byp ? rg : m_mem[h % D]);
    chk("empty", int'(is_free_list_empty), int'(emp && !byp));
    chk("count", int'(free_count), t - h);
    dd = deq && (!emp || byp);
    de = enq && rg != 0 && (!full || dd);
    if (de) begin m_mem[t % D] = rg; t++; end
    r += int'(ret);
    h = fl ? r : h + int'(dd);
    @(posedge clk); #1;
    dequeue = 0; enqueue = 0; enqueue_reg = '0; retire_alloc = 0; flush = 0;
  endtask
  function automatic bit in_list(int v);
    for (int k = r; k < t; k++) if (m_mem[k % D] == v) return 1;
    return 0;
  endfunction
  initial begin
    do_reset();
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 0);
    chk("drain_empty", int'(is_free_list_empty), 1);
    chk("drain_count", int'(free_count), 0);
    step(1, 0, 0, 0, 0);
    chk("deq_empty_count", int'(free_count), 0);
    step(0, 1, 40, 0, 0);
    chk("enq40_phys", int'(phys_reg), 40);
    chk("enq40_count", int'(free_count), 1);
    step(0, 1, 0, 0, 0);
    chk("enq0_count", int'(free_count), 1);
    do_reset();
    step(1, 1, 45, 0, 0);
    chk("full_swap_count", int'(free_count), D);
    for (int i = 0; i < D - 1; i++) step(1, 0, 0, 0, 0);
    chk("full_swap_tail", int'(phys_reg), 45);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    chk("flush_phys", int'(phys_reg), 34);
    chk("flush_count", int'(free_count), 30);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1);
    chk("flush_ret_phys", int'(phys_reg), 34);
    do_reset();
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 50, 0, 0);
`ifdef FREE_LIST_BYPASS_EN
    chk("bypass_count", int'(free_count), 0);
`else
    chk("nobyp_phys", int'(phys_reg), 50);
    chk("nobyp_count", int'(free_count), 1);
`endif
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit deq, enq, ret, fl;
      int rg;
      if ($urandom_range(0, 499) == 0) begin do_reset(); continue; end
      deq = $urandom_range(0, 2) != 0;
      ret = (r < h) && $urandom_range(0, 2) == 0;
      fl  = $urandom_range(0, 24) == 0;
      enq = 0; rg = 0;
      if (t - r < D && $urandom_range(0, 1) == 1) begin
        rg = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 2**PB - 1);
        enq = (rg == 0) || !in_list(rg);
      end
      step(deq, enq, rg, ret, fl);
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
